// File: rtl/button_pkg.sv
// Shared definitions for the button click path.
// State and event encodings plus default window lengths.
package button_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COUNTING = 2'd1,
      ST_REPORT   = 2'd2
   } state_t;

   localparam logic [1:0] EV_SINGLE = 2'd1;
   localparam logic [1:0] EV_DOUBLE = 2'd2;
   localparam logic [1:0] EV_TRIPLE = 2'd3;

   // 0.5 s at 50 MHz, and a short window for simulation
   localparam int WINDOW_50MHZ = 25_000_000;
   localparam int WINDOW_SIM   = 4;
   localparam int CNT_W_DEF    = 25;

endpackage

// File: rtl/click_window_timer.sv
// Inter-press window timer for the click decoder.
// Counts while enabled and flags the last cycle of the window.
module click_window_timer #(
   parameter int WINDOW = 4,
   parameter int CNT_W  = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WINDOW - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last   = (r_cnt == LP_LAST);
   assign o_expire = i_enable && w_last;

   // Wraps to zero on expiry so the count is clean on entry to REPORT
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/click_decoder.sv
// Groups press pulses into single/double/triple click events.
// Events are offered to the consumer over a valid/ready handshake.
module click_decoder
   import button_pkg::*;
#(
   parameter int WINDOW     = WINDOW_50MHZ,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int MAX_CLICKS = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       press_pulse,
   input  logic       event_ready,
   output logic       event_valid,
   output logic [1:0] event_count,
   output logic       busy,
   output logic       dropped
);

   localparam logic [1:0] LP_MAX = 2'(MAX_CLICKS);

   state_t     r_state;
   state_t     w_state_n;
   logic [1:0] r_clicks;
   logic [1:0] w_clicks_n;
   logic [1:0] w_clicks_inc;
   logic [1:0] r_count;
   logic [1:0] w_count_n;
   logic       r_valid;
   logic       w_valid_n;
   logic       r_busy;
   logic       w_busy_n;
   logic       r_drop;
   logic       w_drop_n;
   logic       w_enable;
   logic       w_clear;
   logic       w_expire;
   logic       w_open;

   assign w_enable = (r_state == ST_COUNTING);
   assign w_clear  = !w_enable || press_pulse;

   click_window_timer #(
      .WINDOW (WINDOW),
      .CNT_W  (CNT_W)
   ) u_timer (
      .i_clk    (sys_clk),
      .i_rst_n  (sys_rst_n),
      .i_clear  (w_clear),
      .i_enable (w_enable),
      .o_expire (w_expire)
   );

   // A press opens a new group from IDLE or on the accepting edge in REPORT
   assign w_open = press_pulse &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_REPORT) && event_ready));

   always_comb begin
      w_state_n    = r_state;
      w_clicks_n   = r_clicks;
      w_count_n    = r_count;
      w_valid_n    = r_valid;
      w_busy_n     = r_busy;
      w_drop_n     = 1'b0;
      w_clicks_inc = r_clicks + 2'd1;

      unique case (r_state)
         ST_IDLE: begin
            w_state_n = ST_IDLE;
         end
         ST_COUNTING: begin
            if (press_pulse) begin
               w_clicks_n = w_clicks_inc;
               if (w_clicks_inc == LP_MAX) begin
                  w_state_n = ST_REPORT;
                  w_valid_n = 1'b1;
                  w_count_n = w_clicks_inc;
                  w_busy_n  = 1'b0;
               end
            end else if (w_expire) begin
               w_state_n = ST_REPORT;
               w_valid_n = 1'b1;
               w_count_n = r_clicks;
               w_busy_n  = 1'b0;
            end
         end
         ST_REPORT: begin
            if (event_ready) begin
               w_state_n  = ST_IDLE;
               w_valid_n  = 1'b0;
               w_count_n  = 2'd0;
               w_clicks_n = 2'd0;
               w_busy_n   = 1'b0;
            end else if (press_pulse) begin
               w_drop_n = 1'b1;
            end
         end
         default: begin
            w_state_n  = ST_IDLE;
            w_valid_n  = 1'b0;
            w_count_n  = 2'd0;
            w_clicks_n = 2'd0;
            w_busy_n   = 1'b0;
         end
      endcase

      if (w_open) begin
         w_clicks_n = EV_SINGLE;
         if (LP_MAX == EV_SINGLE) begin
            w_state_n = ST_REPORT;
            w_valid_n = 1'b1;
            w_count_n = EV_SINGLE;
            w_busy_n  = 1'b0;
         end else begin
            w_state_n = ST_COUNTING;
            w_valid_n = 1'b0;
            w_count_n = 2'd0;
            w_busy_n  = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state  <= ST_IDLE;
         r_clicks <= 2'd0;
         r_count  <= 2'd0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_clicks <= w_clicks_n;
         r_count  <= w_count_n;
         r_valid  <= w_valid_n;
         r_busy   <= w_busy_n;
         r_drop   <= w_drop_n;
      end
   end

   assign event_valid = r_valid;
   assign event_count = r_count;
   assign busy        = r_busy;
   assign dropped     = r_drop;

endmodule
